// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator for the UART path.
// Two fractional divider engines are kept: RX can be re-aligned to a start-bit edge,
// while TX runs free. Both share one pending-divisor register, and each engine adopts a
// new divisor at its own next reload, so a change never cuts a period short.
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_BITS  = 4,
    // Rounded CLK_FREQ * 2^FRAC_BITS / (BAUD * OVERSAMPLE)
    parameter int unsigned DEF_DIV    = 32'((64'(CLK_FREQ) * (64'd2 << FRAC_BITS)
                                             + 64'(BAUD) * 64'(OVERSAMPLE))
                                            / (64'd2 * 64'(BAUD) * 64'(OVERSAMPLE)))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    input  logic                 rx_resync,
    output logic                 rx_tick,
    output logic                 rx_sample,
    output logic                 tx_tick
);

    localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);

    localparam logic [PHASE_W-1:0]   HALF_PHASE = PHASE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PHASE_W-1:0]   LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_INT    = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE_INT    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DEF_INT    = DIV_WIDTH'(DEF_DIV >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC   = FRAC_BITS'(DEF_DIV);
    localparam logic [DIV_WIDTH-1:0] RST_CNT    = ((DEF_INT < MIN_INT) ? MIN_INT : DEF_INT)
                                                  - ONE_INT;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] cnt;
        logic [FRAC_BITS-1:0] acc;
    } reload_t;

    // Divisors below 2 would give a tick every cycle or never; hold them at 2.
    function automatic logic [DIV_WIDTH-1:0] clamp_int(input logic [DIV_WIDTH-1:0] v);
        return (v < MIN_INT) ? MIN_INT : v;
    endfunction

    // Reload step: the fractional carry stretches this period by one cycle.
    function automatic reload_t reload(input logic [DIV_WIDTH-1:0] int_v,
                                       input logic [FRAC_BITS-1:0] frac_v,
                                       input logic [FRAC_BITS-1:0] acc_v);
        logic [FRAC_BITS:0] sum;
        reload_t            r;
        sum   = {1'b0, acc_v} + {1'b0, frac_v};
        r.acc = sum[FRAC_BITS-1:0];
        r.cnt = clamp_int(int_v) - ONE_INT + DIV_WIDTH'(sum[FRAC_BITS]);
        return r;
    endfunction

    // Shared pending divisor
    logic [DIV_WIDTH-1:0] pend_int_q, pend_int_d;
    logic [FRAC_BITS-1:0] pend_frac_q, pend_frac_d;

    // RX engine
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [FRAC_BITS-1:0] rx_acc_q, rx_acc_d;
    logic [DIV_WIDTH-1:0] rx_int_q, rx_int_d;
    logic [FRAC_BITS-1:0] rx_frac_q, rx_frac_d;
    logic                 rx_pend_q, rx_pend_d;
    logic [PHASE_W-1:0]   rx_phase_q, rx_phase_d;
    logic                 rx_tick_q, rx_tick_d;
    logic                 rx_sample_q, rx_sample_d;
    reload_t              rx_rl;

    // TX engine
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [FRAC_BITS-1:0] tx_acc_q, tx_acc_d;
    logic [DIV_WIDTH-1:0] tx_int_q, tx_int_d;
    logic [FRAC_BITS-1:0] tx_frac_q, tx_frac_d;
    logic                 tx_pend_q, tx_pend_d;
    logic [PHASE_W-1:0]   tx_phase_q, tx_phase_d;
    logic                 tx_tick_q, tx_tick_d;
    reload_t              tx_rl;

    // Pending divisor capture; works regardless of en.
    always_comb begin
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        if (div_load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
        end
    end

    // RX engine next state: resync beats both en and a coincident reload.
    always_comb begin
        rx_cnt_d    = rx_cnt_q;
        rx_acc_d    = rx_acc_q;
        rx_int_d    = rx_int_q;
        rx_frac_d   = rx_frac_q;
        rx_pend_d   = rx_pend_q;
        rx_phase_d  = rx_phase_q;
        rx_tick_d   = 1'b0;
        rx_sample_d = 1'b0;
        rx_rl       = '0;

        if (rx_resync) begin
            if (rx_pend_q) begin
                rx_int_d  = pend_int_q;
                rx_frac_d = pend_frac_q;
                rx_pend_d = 1'b0;
            end
            // Half a tick period puts the first tick near the middle of a sub-bit.
            rx_cnt_d   = clamp_int(rx_int_d) >> 1;
            rx_acc_d   = '0;
            rx_phase_d = '0;
        end else if (en) begin
            if (rx_cnt_q == '0) begin
                if (rx_pend_q) begin
                    rx_int_d  = pend_int_q;
                    rx_frac_d = pend_frac_q;
                    rx_pend_d = 1'b0;
                end
                rx_rl       = reload(rx_int_d, rx_frac_d, rx_acc_q);
                rx_cnt_d    = rx_rl.cnt;
                rx_acc_d    = rx_rl.acc;
                rx_phase_d  = rx_phase_q + PHASE_W'(1);
                rx_tick_d   = 1'b1;
                rx_sample_d = (rx_phase_q == HALF_PHASE);
            end else begin
                rx_cnt_d = rx_cnt_q - ONE_INT;
            end
        end

        // A load on the adoption edge keeps the newer value pending.
        if (div_load) begin
            rx_pend_d = 1'b1;
        end
    end

    // TX engine next state: free-running, only en and divisor loads affect it.
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        tx_acc_d   = tx_acc_q;
        tx_int_d   = tx_int_q;
        tx_frac_d  = tx_frac_q;
        tx_pend_d  = tx_pend_q;
        tx_phase_d = tx_phase_q;
        tx_tick_d  = 1'b0;
        tx_rl      = '0;

        if (en) begin
            if (tx_cnt_q == '0) begin
                if (tx_pend_q) begin
                    tx_int_d  = pend_int_q;
                    tx_frac_d = pend_frac_q;
                    tx_pend_d = 1'b0;
                end
                tx_rl      = reload(tx_int_d, tx_frac_d, tx_acc_q);
                tx_cnt_d   = tx_rl.cnt;
                tx_acc_d   = tx_rl.acc;
                tx_phase_d = tx_phase_q + PHASE_W'(1);
                tx_tick_d  = (tx_phase_q == LAST_PHASE);
            end else begin
                tx_cnt_d = tx_cnt_q - ONE_INT;
            end
        end

        if (div_load) begin
            tx_pend_d = 1'b1;
        end
    end

    // Pending divisor register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_int_q  <= DEF_INT;
            pend_frac_q <= DEF_FRAC;
        end else begin
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
        end
    end

    // RX engine state and registered RX pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q    <= RST_CNT;
            rx_acc_q    <= '0;
            rx_int_q    <= DEF_INT;
            rx_frac_q   <= DEF_FRAC;
            rx_pend_q   <= 1'b0;
            rx_phase_q  <= '0;
            rx_tick_q   <= 1'b0;
            rx_sample_q <= 1'b0;
        end else begin
            rx_cnt_q    <= rx_cnt_d;
            rx_acc_q    <= rx_acc_d;
            rx_int_q    <= rx_int_d;
            rx_frac_q   <= rx_frac_d;
            rx_pend_q   <= rx_pend_d;
            rx_phase_q  <= rx_phase_d;
            rx_tick_q   <= rx_tick_d;
            rx_sample_q <= rx_sample_d;
        end
    end

    // TX engine state and registered TX pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q   <= RST_CNT;
            tx_acc_q   <= '0;
            tx_int_q   <= DEF_INT;
            tx_frac_q  <= DEF_FRAC;
            tx_pend_q  <= 1'b0;
            tx_phase_q <= '0;
            tx_tick_q  <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_acc_q   <= tx_acc_d;
            tx_int_q   <= tx_int_d;
            tx_frac_q  <= tx_frac_d;
            tx_pend_q  <= tx_pend_d;
            tx_phase_q <= tx_phase_d;
            tx_tick_q  <= tx_tick_d;
        end
    end

    assign rx_tick   = rx_tick_q;
    assign rx_sample = rx_sample_q;
    assign tx_tick   = tx_tick_q;

endmodule
